bp_clint_responder: RTL and testbench

//  Memory-mapped responder for the CLINT device region (clint_dev_gp). Terminates

---
 rtl/bp_common_pkg.sv | 10 +
 rtl/bp_clint_mtime.sv | 48 ++++
 rtl/bp_clint_responder.sv | 155 +++++++++++++++
 tb/tb_bp_clint_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// Shared platform constants: CLINT device id and the CLINT register addresses.
package bp_common_pkg;

    localparam logic [3:0]  clint_dev_gp              = 4'd1;

    localparam logic [63:0] mipi_reg_base_addr_gp     = 64'h0000_0000_0030_0000;
    localparam logic [63:0] mtimecmp_reg_base_addr_gp = 64'h0000_0000_0030_4000;
    localparam logic [63:0] mtime_reg_addr_gp         = 64'h0000_0000_0030_bff8;

endpackage

// File: rtl/bp_clint_mtime.sv
// Free-running mtime counter with a prescaler and half-word write enables.
module bp_clint_mtime
    import bp_common_pkg::*;
#(
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned timebase_div_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_lo_i,
    input  logic                    w_hi_i,
    input  logic [data_width_p-1:0] wdata_i,
    output logic [data_width_p-1:0] mtime_o
);

    localparam int unsigned half_lp    = data_width_p / 2;
    localparam int unsigned presc_w_lp = (timebase_div_p > 1) ? $clog2(timebase_div_p) : 1;

    logic [presc_w_lp-1:0]   presc_q, presc_d;
    logic [data_width_p-1:0] mtime_q, mtime_d;
    logic                    tick;

    // A store in a tick cycle wins; the prescaler keeps running regardless of stores.
    always_comb begin
        tick    = (presc_q == presc_w_lp'(timebase_div_p - 1));
        presc_d = tick ? '0 : presc_q + presc_w_lp'(1);
        mtime_d = mtime_q;
        if (w_lo_i || w_hi_i) begin
            if (w_lo_i) mtime_d[half_lp-1:0]            = wdata_i[half_lp-1:0];
            if (w_hi_i) mtime_d[data_width_p-1:half_lp] = wdata_i[data_width_p-1:half_lp];
        end else if (tick) begin
            mtime_d = mtime_q + data_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/bp_clint_responder.sv
// CLINT responder: decodes uncached commands to mipi/mtimecmp/mtime and
// drives the software and timer interrupt lines.
module bp_clint_responder
    import bp_common_pkg::*;
#(
    parameter int unsigned paddr_width_p  = 40,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned timebase_div_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_w_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [1:0]               cmd_size_i,
    input  logic [data_width_p-1:0]  cmd_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic                     resp_w_o,
    output logic                     resp_err_o,
    output logic [data_width_p-1:0]  resp_data_o,

    output logic                     software_irq_o,
    output logic                     timer_irq_o
);

    localparam int unsigned half_lp = data_width_p / 2;

    localparam logic [paddr_width_p-1:0] mipi_lo_lp  = paddr_width_p'(mipi_reg_base_addr_gp);
    localparam logic [paddr_width_p-1:0] mipi_hi_lp  = paddr_width_p'(mipi_reg_base_addr_gp + 64'd4);
    localparam logic [paddr_width_p-1:0] cmp_lo_lp   = paddr_width_p'(mtimecmp_reg_base_addr_gp);
    localparam logic [paddr_width_p-1:0] cmp_hi_lp   = paddr_width_p'(mtimecmp_reg_base_addr_gp + 64'd4);
    localparam logic [paddr_width_p-1:0] mtime_lo_lp = paddr_width_p'(mtime_reg_addr_gp);
    localparam logic [paddr_width_p-1:0] mtime_hi_lp = paddr_width_p'(mtime_reg_addr_gp + 64'd4);

    typedef enum logic {e_ready, e_resp} state_e;

    state_e                  state_q, state_d;
    logic                    resp_w_q, resp_w_d;
    logic                    resp_err_q, resp_err_d;
    logic [data_width_p-1:0] resp_data_q, resp_data_d;
    logic                    mipi_q, mipi_d;
    logic [data_width_p-1:0] mtimecmp_q, mtimecmp_d;
    logic                    timer_irq_q;
    logic [data_width_p-1:0] mtime;

    logic hit_lo, hit_hi, legal, sel_mipi, sel_cmp, sel_mtime;
    logic accept, wr, wr_lo, wr_hi;
    logic [data_width_p-1:0] wdata, rd_val, rd_data;

    // Address decode: exact match on the low or high word of each 8-byte register.
    always_comb begin
        hit_lo    = (cmd_addr_i == mipi_lo_lp) || (cmd_addr_i == cmp_lo_lp)
                 || (cmd_addr_i == mtime_lo_lp);
        hit_hi    = (cmd_addr_i == mipi_hi_lp) || (cmd_addr_i == cmp_hi_lp)
                 || (cmd_addr_i == mtime_hi_lp);
        legal     = ((cmd_size_i == 2'd3) && hit_lo)
                 || ((cmd_size_i == 2'd2) && (hit_lo || hit_hi));
        sel_mipi  = legal && ((cmd_addr_i == mipi_lo_lp)  || (cmd_addr_i == mipi_hi_lp));
        sel_cmp   = legal && ((cmd_addr_i == cmp_lo_lp)   || (cmd_addr_i == cmp_hi_lp));
        sel_mtime = legal && ((cmd_addr_i == mtime_lo_lp) || (cmd_addr_i == mtime_hi_lp));

        rd_val = '0;
        if (sel_mipi)       rd_val = data_width_p'(mipi_q);
        else if (sel_cmp)   rd_val = mtimecmp_q;
        else if (sel_mtime) rd_val = mtime;

        if (!legal)                  rd_data = '0;
        else if (cmd_size_i == 2'd3) rd_data = rd_val;
        else if (hit_hi)             rd_data = data_width_p'(rd_val[data_width_p-1:half_lp]);
        else                         rd_data = data_width_p'(rd_val[half_lp-1:0]);

        // Word stores replicate the low word so either half can take it.
        wdata  = (cmd_size_i == 2'd3) ? cmd_data_i : {2{cmd_data_i[half_lp-1:0]}};
        accept = (state_q == e_ready) && cmd_v_i;
        wr     = accept && cmd_w_i && legal;
        wr_lo  = wr && ((cmd_size_i == 2'd3) || !hit_hi);
        wr_hi  = wr && ((cmd_size_i == 2'd3) || hit_hi);
    end

    // Register write ports.
    always_comb begin
        mipi_d     = mipi_q;
        mtimecmp_d = mtimecmp_q;
        if (sel_mipi && wr_lo) mipi_d = wdata[0];
        if (sel_cmp && wr_lo)  mtimecmp_d[half_lp-1:0]            = wdata[half_lp-1:0];
        if (sel_cmp && wr_hi)  mtimecmp_d[data_width_p-1:half_lp] = wdata[data_width_p-1:half_lp];
    end

    bp_clint_mtime #(
        .data_width_p  (data_width_p),
        .timebase_div_p(timebase_div_p)
    ) u_mtime (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .w_lo_i (sel_mtime && wr_lo),
        .w_hi_i (sel_mtime && wr_hi),
        .wdata_i(wdata),
        .mtime_o(mtime)
    );

    // Handshake FSM; the response is captured at accept and held until consumed.
    always_comb begin
        state_d     = state_q;
        resp_w_d    = resp_w_q;
        resp_err_d  = resp_err_q;
        resp_data_d = resp_data_q;
        case (state_q)
            e_ready: begin
                if (accept) begin
                    state_d     = e_resp;
                    resp_w_d    = cmd_w_i;
                    resp_err_d  = !legal;
                    resp_data_d = cmd_w_i ? '0 : rd_data;
                end
            end
            e_resp: begin
                if (resp_yumi_i) state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            resp_w_q    <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            mipi_q      <= 1'b0;
            mtimecmp_q  <= '1;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_w_q    <= resp_w_d;
            resp_err_q  <= resp_err_d;
            resp_data_q <= resp_data_d;
            mipi_q      <= mipi_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= (mtime >= mtimecmp_q);
        end
    end

    assign cmd_ready_o    = (state_q == e_ready);
    assign resp_v_o       = (state_q == e_resp);
    assign resp_w_o       = resp_w_q;
    assign resp_err_o     = resp_err_q;
    assign resp_data_o    = resp_data_q;
    assign software_irq_o = mipi_q;
    assign timer_irq_o    = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Self-checking bench for bp_clint_responder: vector table plus hand-written
// sequences for reset, timer interrupt timing, back-pressure and mtime wrap.
module tb_bp_clint_responder;

    localparam logic [39:0] MIPI  = 40'h30_0000;
    localparam logic [39:0] CMP   = 40'h30_4000;
    localparam logic [39:0] MTIME = 40'h30_bff8;

    logic        clk, rst;
    logic        cmd_v, cmd_ready, cmd_w;
    logic [39:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [63:0] cmd_data;
    logic        resp_v, resp_yumi, resp_w, resp_err;
    logic [63:0] resp_data;
    logic        sw_irq, tm_irq;

    bp_clint_responder #(
        .paddr_width_p (40),
        .data_width_p  (64),
        .timebase_div_p(8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .cmd_v_i       (cmd_v),
        .cmd_ready_o   (cmd_ready),
        .cmd_w_i       (cmd_w),
        .cmd_addr_i    (cmd_addr),
        .cmd_size_i    (cmd_size),
        .cmd_data_i    (cmd_data),
        .resp_v_o      (resp_v),
        .resp_yumi_i   (resp_yumi),
        .resp_w_o      (resp_w),
        .resp_err_o    (resp_err),
        .resp_data_o   (resp_data),
        .software_irq_o(sw_irq),
        .timer_irq_o   (tm_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; mtime ticks on every edge where cyc % 8 == 0.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic        w;
        logic        err;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic        w;
        logic [39:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        logic        err;
        logic [63:0] rdata;
        logic        sw;
        logic        ta;
        logic        tn;
        string       name;
    } row_t;

    exp_t sb_q[$];
    row_t rows[$];
    int   n_err = 0;
    int   n_chk = 0;

    // Last mtime store: value mt_v written at edge ks_g.
    int          ks_g = 0;
    logic [63:0] mt_v = '0;

    function automatic logic [63:0] mtime_exp(input int k);
        return mt_v + 64'((k / 8) - (ks_g / 8));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic w, input logic [39:0] addr, input logic [1:0] size,
                           input logic [63:0] data, input logic err, input logic [63:0] rdata,
                           input logic sw, input logic ta, input logic tn, input string name);
        row_t r;
        r.w = w; r.addr = addr; r.size = size; r.data = data; r.err = err;
        r.rdata = rdata; r.sw = sw; r.ta = ta; r.tn = tn; r.name = name;
        rows.push_back(r);
    endtask

    // One command: drive, expect response one cycle after accept, consume it.
    task automatic send(input logic w, input logic [39:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic exp_err, input logic [63:0] exp_data,
                        input bit use_mtime, input string name,
                        output int acc, output logic sw_a, output logic ta, output logic tn);
        exp_t e;
        int   waited;
        @(negedge clk);
        check({name, ".ready"}, 64'(cmd_ready), 64'd1);
        cmd_v = 1'b1; cmd_w = w; cmd_addr = addr; cmd_size = size; cmd_data = data;
        acc    = cyc + 1;
        e.w    = w;
        e.err  = exp_err;
        e.data = use_mtime ? mtime_exp(acc - 1) : exp_data;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_v  = 1'b0;
        waited = 0;
        while (!resp_v && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({name, ".latency"}, 64'(waited), 64'd0);
        e = sb_q.pop_front();
        check({name, ".w"},    64'(resp_w),   64'(e.w));
        check({name, ".err"},  64'(resp_err), 64'(e.err));
        check({name, ".data"}, resp_data,     e.data);
        sw_a = sw_irq;
        ta   = tm_irq;
        resp_yumi = 1'b1;
        @(posedge clk);
        #1;
        resp_yumi = 1'b0;
        tn = tm_irq;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc, guard, rose;
        logic        sw_a, ta, tn;
        logic [63:0] old;
        exp_t        e;

        rst = 1'b1; cmd_v = 1'b0; cmd_w = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_data = '0; resp_yumi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.resp_v", 64'(resp_v), 64'd0);
        check("reset.ready",  64'(cmd_ready), 64'd1);
        check("reset.sw_irq", 64'(sw_irq), 64'd0);
        check("reset.tm_irq", 64'(tm_irq), 64'd0);

        // Reset asserted while a response is pending drops it.
        cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = CMP; cmd_size = 2'd3;
        @(negedge clk);
        cmd_v = 1'b0;
        check("midrst.resp_v_before", 64'(resp_v), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst.resp_v_async", 64'(resp_v), 64'd0);
        @(negedge clk);
        check("midrst.resp_v", 64'(resp_v),    64'd0);
        check("midrst.ready",  64'(cmd_ready), 64'd1);
        check("midrst.err",    64'(resp_err),  64'd0);
        check("midrst.data",   resp_data,      64'd0);
        rst = 1'b0; ks_g = 0; mt_v = '0;
        send(1'b0, CMP, 2'd3, '0, 1'b0, '1, 1'b0, "t1.ld_cmp", acc, sw_a, ta, tn);
        check("t1.sw", 64'(sw_a), 64'd0);
        check("t1.tm", 64'(tn),   64'd0);

        //      w     addr        sz    data                    err   rdata                   sw    ta    tn
        add_row(1'b0, MIPI,       2'd3, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, "v.ld_mipi0");
        add_row(1'b1, MIPI,       2'd3, 64'h3,                  1'b0, 64'h0,                  1'b1, 1'b0, 1'b0, "v.st_mipi3");
        add_row(1'b0, MIPI,       2'd3, 64'h0,                  1'b0, 64'h1,                  1'b1, 1'b0, 1'b0, "v.ld_mipi1");
        add_row(1'b0, MIPI + 4,   2'd2, 64'h0,                  1'b0, 64'h0,                  1'b1, 1'b0, 1'b0, "v.ld_mipi_hi");
        add_row(1'b0, MIPI,       2'd2, 64'h0,                  1'b0, 64'h1,                  1'b1, 1'b0, 1'b0, "v.ld_mipi_lo");
        add_row(1'b1, MIPI,       2'd3, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, "v.st_mipi0");
        add_row(1'b1, CMP,        2'd3, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b1, "v.st_cmp0");
        add_row(1'b0, CMP,        2'd3, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b1, 1'b1, "v.ld_cmp0");
        add_row(1'b1, CMP + 4,    2'd2, 64'hDEAD_BEEF,          1'b0, 64'h0,                  1'b0, 1'b1, 1'b0, "v.st_cmp_hi");
        add_row(1'b0, CMP,        2'd3, 64'h0,                  1'b0, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0, 1'b0, "v.ld_cmp_a");
        add_row(1'b1, CMP,        2'd2, 64'hFFFF_0000_1234_5678, 1'b0, 64'h0,                 1'b0, 1'b0, 1'b0, "v.st_cmp_lo");
        add_row(1'b0, CMP,        2'd3, 64'h0,                  1'b0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1'b0, 1'b0, "v.ld_cmp_b");
        add_row(1'b0, CMP + 4,    2'd2, 64'h0,                  1'b0, 64'hDEAD_BEEF,          1'b0, 1'b0, 1'b0, "v.ld_cmp_hi");
        add_row(1'b0, 40'h30_1000, 2'd3, 64'h0,                 1'b1, 64'h0,                  1'b0, 1'b0, 1'b0, "v.unmapped");
        add_row(1'b1, MIPI,       2'd0, 64'h1,                  1'b1, 64'h0,                  1'b0, 1'b0, 1'b0, "v.st_1b");
        add_row(1'b0, MTIME + 4,  2'd3, 64'h0,                  1'b1, 64'h0,                  1'b0, 1'b0, 1'b0, "v.misalign8");
        add_row(1'b0, CMP,        2'd1, 64'h0,                  1'b1, 64'h0,                  1'b0, 1'b0, 1'b0, "v.ld_2b");
        add_row(1'b1, CMP + 8,    2'd3, 64'h0,                  1'b1, 64'h0,                  1'b0, 1'b0, 1'b0, "v.st_adjacent");
        add_row(1'b0, MIPI,       2'd3, 64'h0,                  1'b0, 64'h0,                  1'b0, 1'b0, 1'b0, "v.ld_mipi_kept");
        add_row(1'b0, CMP,        2'd3, 64'h0,                  1'b0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1'b0, 1'b0, "v.ld_cmp_kept");

        foreach (rows[i]) begin
            send(rows[i].w, rows[i].addr, rows[i].size, rows[i].data, rows[i].err,
                 rows[i].rdata, 1'b0, rows[i].name, acc, sw_a, ta, tn);
            check({rows[i].name, ".sw"},   64'(sw_a), 64'(rows[i].sw));
            check({rows[i].name, ".tm_a"}, 64'(ta),   64'(rows[i].ta));
            check({rows[i].name, ".tm_n"}, 64'(tn),   64'(rows[i].tn));
        end

        // Timer interrupt rises exactly one edge after mtime reaches mtimecmp.
        send(1'b1, MTIME, 2'd3, 64'h10, 1'b0, 64'h0, 1'b0, "t3.st_mtime", acc, sw_a, ta, tn);
        ks_g = acc; mt_v = 64'h10;
        send(1'b1, CMP, 2'd3, 64'h12, 1'b0, 64'h0, 1'b0, "t3.st_cmp", acc, sw_a, ta, tn);
        rose = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("t3.tm_irq", 64'(tm_irq), 64'(mtime_exp(cyc - 1) >= 64'h12));
            if (tm_irq && rose < 0) rose = cyc;
        end
        check("t3.rose", 64'(rose >= 0 && rose - ks_g <= 17), 64'd1);
        send(1'b0, MTIME, 2'd3, 64'h0, 1'b0, 64'h0, 1'b1, "t3.ld_mtime", acc, sw_a, ta, tn);

        // Back-pressure: response held, pending command not accepted.
        @(negedge clk);
        cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = CMP; cmd_size = 2'd3;
        e.w = 1'b0; e.err = 1'b0; e.data = 64'h12;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_w = 1'b1; cmd_addr = MIPI; cmd_data = 64'h1;
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("t6.resp_v", 64'(resp_v),    64'd1);
            check("t6.ready",  64'(cmd_ready), 64'd0);
            check("t6.w",      64'(resp_w),    64'(e.w));
            check("t6.err",    64'(resp_err),  64'(e.err));
            check("t6.data",   resp_data,      e.data);
            @(negedge clk);
        end
        cmd_v = 1'b0;
        resp_yumi = 1'b1;
        @(posedge clk);
        #1 resp_yumi = 1'b0;
        @(negedge clk);
        check("t6.sw_not_stored", 64'(sw_irq), 64'd0);
        send(1'b0, MIPI, 2'd3, 64'h0, 1'b0, 64'h0, 1'b0, "t6.ld_mipi", acc, sw_a, ta, tn);

        // mtime wraps from all-ones to zero on the next increment.
        send(1'b1, MTIME, 2'd3, '1, 1'b0, 64'h0, 1'b0, "t6.st_ones", acc, sw_a, ta, tn);
        ks_g = acc; mt_v = '1;
        guard = 0;
        while (cyc / 8 <= ks_g / 8 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        send(1'b0, MTIME, 2'd3, 64'h0, 1'b0, 64'h0, 1'b1, "t6.ld_wrap", acc, sw_a, ta, tn);

        // High-word store to mtime keeps the running low word.
        send(1'b1, MTIME + 4, 2'd2, 64'h5, 1'b0, 64'h0, 1'b0, "t7.st_hi", acc, sw_a, ta, tn);
        old  = mtime_exp(acc - 1);
        mt_v = {32'h5, old[31:0]};
        ks_g = acc;
        send(1'b0, MTIME, 2'd3, 64'h0, 1'b0, 64'h0, 1'b1, "t7.ld_mtime", acc, sw_a, ta, tn);
        send(1'b0, MTIME + 4, 2'd2, 64'h0, 1'b0, 64'h5, 1'b0, "t7.ld_hi", acc, sw_a, ta, tn);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
